// File: rtl/fpr_of_int_if.sv
// Start/done handshake bundle for the integer-to-binary64 converter.
// Optional `scale` operand exists only when FPR_SCALED_EN is defined.
interface fpr_of_int_if #(
   parameter int INT_W = 64
);
   logic             start;
   logic [INT_W-1:0] input_a;
`ifdef FPR_SCALED_EN
   logic [10:0]      scale;
`endif
   logic [63:0]      result;
   logic             done;
   logic             busy;
   logic             inexact;

   modport master (
`ifdef FPR_SCALED_EN
      output scale,
`endif
      output start, input_a,
      input  result, done, busy, inexact
   );

   modport slave (
`ifdef FPR_SCALED_EN
      input  scale,
`endif
      input  start, input_a,
      output result, done, busy, inexact
   );
endinterface

// File: rtl/fpr_of_int.sv
// Signed integer to IEEE-754 binary64, round-to-nearest-even, fixed latency.
// Define FPR_SCALED_EN to add a signed power-of-two scale (fpr_scaled).
module fpr_of_int #(
   parameter int INT_W    = 64,
   parameter int EXP_BIAS = 1023
) (
   input  logic        clk,
   input  logic        rst,
   fpr_of_int_if.slave io
);
   localparam int NSTEP = $clog2(INT_W);

   typedef enum logic [2:0] {IDLE, ABS, NORM, ROUND, PACK} state_t;

   state_t           state_q, state_d;
   logic [INT_W-1:0] a_q, a_d;
   logic [INT_W-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic [6:0]       lz_q, lz_d;
   logic [2:0]       step_q, step_d;
   logic [51:0]      frac_q, frac_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             rinx_q, rinx_d;
   logic [63:0]      result_q, result_d;
   logic             inexact_q, inexact_d;
   logic             done_q, done_d;
`ifdef FPR_SCALED_EN
   logic [10:0]      scale_q, scale_d;
   logic [13:0]      exp_s;
`endif
   logic [10:0]      exp11;
   logic [6:0]       sh;
   logic [64:0]      ext;
   logic             guard, sticky, inc;
   logic [53:0]      sig;

   // Left-justified magnitude padded so kept/guard/sticky sit at fixed bits for either INT_W.
   assign ext    = {mag_q, {(65-INT_W){1'b0}}};
   assign guard  = ext[11];
   assign sticky = |ext[10:0];
   assign inc    = guard & (sticky | ext[12]);
   assign sig    = {1'b0, ext[64:12]} + {53'd0, inc};
   assign sh     = 7'(INT_W) >> (step_q + 3'd1);
   assign exp11  = 11'(EXP_BIAS + INT_W - 1) - {4'd0, lz_q} + {10'd0, carry_q};
`ifdef FPR_SCALED_EN
   assign exp_s  = 14'(EXP_BIAS + INT_W - 1) - {7'd0, lz_q} + {13'd0, carry_q}
                 + {{3{scale_q[10]}}, scale_q};
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      mag_d     = mag_q;
      sign_d    = sign_q;
      lz_d      = lz_q;
      step_d    = step_q;
      frac_d    = frac_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      rinx_d    = rinx_q;
      result_d  = result_q;
      inexact_d = inexact_q;
      done_d    = 1'b0;
`ifdef FPR_SCALED_EN
      scale_d   = scale_q;
`endif
      case (state_q)
         IDLE: if (io.start) begin
            a_d     = io.input_a;
`ifdef FPR_SCALED_EN
            scale_d = io.scale;
`endif
            state_d = ABS;
         end
         ABS: begin
            sign_d  = a_q[INT_W-1];
            mag_d   = a_q[INT_W-1] ? ('0 - a_q) : a_q;
            lz_d    = '0;
            step_d  = '0;
            state_d = NORM;
         end
         NORM: begin
            if ((mag_q >> (7'(INT_W) - sh)) == '0) begin
               mag_d = mag_q << sh;
               lz_d  = lz_q + sh;
            end
            if (step_q == 3'(NSTEP-1)) state_d = ROUND;
            else                       step_d  = step_q + 3'd1;
         end
         ROUND: begin
            frac_d  = sig[51:0];
            carry_d = sig[53];
            // A normalised non-zero magnitude always leaves bit 52 or the carry set.
            zero_d  = ~(sig[53] | sig[52]);
            rinx_d  = guard | sticky;
            state_d = PACK;
         end
         PACK: begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (zero_q) begin
               result_d  = 64'h0;
               inexact_d = 1'b0;
`ifdef FPR_SCALED_EN
            end else if ($signed(exp_s) >= 14'sd2047) begin
               result_d  = {sign_q, 11'h7FF, 52'h0};
               inexact_d = 1'b1;
            end else if ($signed(exp_s) <= 14'sd0) begin
               result_d  = {sign_q, 63'h0};
               inexact_d = 1'b1;
            end else begin
               result_d  = {sign_q, exp_s[10:0], carry_q ? 52'h0 : frac_q};
               inexact_d = rinx_q;
            end
`else
            end else begin
               result_d  = {sign_q, exp11, carry_q ? 52'h0 : frac_q};
               inexact_d = rinx_q;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         mag_q     <= '0;
         sign_q    <= 1'b0;
         lz_q      <= '0;
         step_q    <= '0;
         frac_q    <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         rinx_q    <= 1'b0;
         result_q  <= 64'h0;
         inexact_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef FPR_SCALED_EN
         scale_q   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         mag_q     <= mag_d;
         sign_q    <= sign_d;
         lz_q      <= lz_d;
         step_q    <= step_d;
         frac_q    <= frac_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         rinx_q    <= rinx_d;
         result_q  <= result_d;
         inexact_q <= inexact_d;
         done_q    <= done_d;
`ifdef FPR_SCALED_EN
         scale_q   <= scale_d;
`endif
      end
   end

`ifndef FPR_SCALED_EN
   // exp11 feeds PACK only in the unscaled build.
`endif
   assign io.result  = result_q;
   assign io.inexact = inexact_q;
   assign io.done    = done_q;
   assign io.busy    = (state_q != IDLE);
endmodule
